// File: rtl/mips32_ifetch_queue_if.sv
// ============================================================================
// Module   : mips32_ifetch_queue_if
// Purpose  : Instruction-memory request/response and ID-stage handshake bundle
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips32_ifetch_queue_if #(
  parameter int ADDR_W = 10
) ();
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              id_valid;
  logic [31:0]       id_ir;
  logic [31:0]       id_npc;
  logic              id_ready;

  // master is the fetch unit; slave is the memory/decode side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_ir, id_npc,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_ir, id_npc,
    output id_ready
  );
endinterface

`default_nettype wire

// File: rtl/mips32_ifetch_queue.sv
// ============================================================================
// Module   : mips32_ifetch_queue
// Purpose  : PC owner, imem request issue and in-order prefetch queue to ID
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips32_ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   halted,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            pc,
  mips32_ifetch_queue_if.master  bus
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      ir_q  [DEPTH];
  logic [31:0]      ir_d  [DEPTH];
  logic [31:0]      npc_q [DEPTH];
  logic [31:0]      npc_d [DEPTH];
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
  logic [31:0]      tag_q [DEPTH];
  logic [31:0]      tag_d [DEPTH];

  logic             req_valid;
  logic             req_fire;
  logic             rsp_take;
  logic             rsp_drop;
  logic             deq;
  logic [CNT_W-1:0] outstanding_nxt;

  // Credit covers both buffered and in-flight words, so an accepted
  // response always finds a free queue slot.
  always_comb begin
    req_valid = !rst && !halted && !redirect_valid &&
                (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C);
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_drop  = bus.imem_rsp_valid && (drop_q != '0);
    rsp_take  = bus.imem_rsp_valid && (drop_q == '0);
    deq       = (count_q != '0) && bus.id_ready;
    outstanding_nxt = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
  end

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_nxt;
    drop_d        = drop_q - CNT_W'(rsp_drop);
    head_d        = head_q;
    tail_d        = tail_q;
    ir_d          = ir_q;
    npc_d         = npc_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    tag_d         = tag_q;

    if (req_fire) begin
      pc_d            = pc_q + 32'd1;
      tag_d[tag_wr_q] = pc_q + 32'd1;
      tag_wr_d        = tag_wr_q + PTR_W'(1);
    end

    if (rsp_take) begin
      ir_d[tail_q]  = bus.imem_rsp_data;
      npc_d[tail_q] = tag_q[tag_rd_q];
      tail_d        = tail_q + PTR_W'(1);
      tag_rd_d      = tag_rd_q + PTR_W'(1);
    end

    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(rsp_take) - CNT_W'(deq);

    // Everything still in flight belongs to the abandoned stream; a word
    // returning this very cycle is already excluded from outstanding_nxt.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
      drop_d   = outstanding_nxt;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        npc_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      ir_q          <= ir_d;
      npc_q         <= npc_d;
      tag_q         <= tag_d;
    end
  end

  assign pc                 = pc_q;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q[ADDR_W-1:0];
  assign bus.id_valid       = (count_q != '0);
  assign bus.id_ir          = ir_q[head_q];
  assign bus.id_npc         = npc_q[head_q];

endmodule

`default_nettype wire

// File: tb/tb_mips32_ifetch_queue.sv
// ============================================================================
// Module   : tb_mips32_ifetch_queue
// Purpose  : Directed self-checking bench for the instruction-fetch queue
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips32_ifetch_queue;

  logic        clk1;
  logic        rst;
  logic        halted;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;

  logic [31:0] mem [1024];

  typedef struct {
    logic [9:0] addr;
    int         due;
  } pend_t;
  pend_t pend[$];

  mips32_ifetch_queue_if #(.ADDR_W(10)) bus ();

  mips32_ifetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (10),
    .RESET_PC (32'd0)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .halted         (halted),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .bus            (bus.master)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // In-order memory with a programmable latency of lat cycles
  always @(posedge clk1) begin
    if (rst) begin
      pend.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      if (bus.imem_rsp_valid) pend.delete(0);
      if (bus.imem_req_valid && bus.imem_req_ready)
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem[pend[0].addr];
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk1);
    rst            = 1'b1;
    halted         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.id_ready   = rdy;
    #1;
    check("rst_id_valid",  32'(bus.id_valid), 32'd0);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_id_ir",     bus.id_ir, 32'd0);
    check("rst_id_npc",    bus.id_npc, 32'd0);
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    #1;
    check("rel_pc",        pc, 32'd0);
    check("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("rel_req_addr",  32'(bus.imem_req_addr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst                = 1'b1;
    halted             = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;

    // Streaming with a 1-cycle memory
    lat = 1;
    do_reset(1'b1);
    @(negedge clk1);
    check("stream_first_empty", 32'(bus.id_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk1);
      check("stream_valid", 32'(bus.id_valid), 32'd1);
      check("stream_ir",    bus.id_ir, 32'hA000_0000 + 32'(i));
      check("stream_npc",   bus.id_npc, 32'(i + 1));
    end

    // Mid-run reset is exercised inside do_reset; then backpressure
    do_reset(1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk1);
      check("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("bp_req_addr",  32'(bus.imem_req_addr), 32'(k));
    end
    @(negedge clk1);
    check("bp_stall_a", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk1);
    check("bp_stall_b", 32'(bus.imem_req_valid), 32'd0);
    check("bp_head_ir", bus.id_ir, 32'hA000_0000);
    @(negedge clk1);
    check("bp_stall_c", 32'(bus.imem_req_valid), 32'd0);
    bus.id_ready = 1'b1;
    @(negedge clk1);
    bus.id_ready = 1'b0;
    check("bp_one_more_valid", 32'(bus.imem_req_valid), 32'd1);
    check("bp_one_more_addr",  32'(bus.imem_req_addr), 32'd4);
    check("bp_next_ir",        bus.id_ir, 32'hA000_0001);
    check("bp_next_npc",       bus.id_npc, 32'd2);
    @(negedge clk1);
    check("bp_stall_d", 32'(bus.imem_req_valid), 32'd0);

    // Redirect with two requests in flight on a 3-cycle memory
    lat = 3;
    do_reset(1'b1);
    @(negedge clk1);
    check("rd_req_addr1", 32'(bus.imem_req_addr), 32'd1);
    @(negedge clk1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    #1;
    check("rd_no_req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    #1;
    check("rd_pc",        pc, 32'h20);
    check("rd_req_addr",  32'(bus.imem_req_addr), 32'h20);
    check("rd_req_valid", 32'(bus.imem_req_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk1);
      check("rd_dropped_empty", 32'(bus.id_valid), 32'd0);
    end
    @(negedge clk1);
    check("rd_valid", 32'(bus.id_valid), 32'd1);
    check("rd_ir",    bus.id_ir, 32'hA000_0020);
    check("rd_npc",   bus.id_npc, 32'h21);
    @(negedge clk1);
    check("rd_ir2",   bus.id_ir, 32'hA000_0021);
    check("rd_npc2",  bus.id_npc, 32'h22);

    // Redirect, response and dequeue in the same cycle
    lat = 1;
    do_reset(1'b0);
    @(negedge clk1);
    @(negedge clk1);
    check("col_head_valid", 32'(bus.id_valid), 32'd1);
    check("col_head_ir",    bus.id_ir, 32'hA000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    bus.id_ready   = 1'b1;
    #1;
    check("col_no_req", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk1);
    redirect_valid = 1'b0;
    #1;
    check("col_empty",     32'(bus.id_valid), 32'd0);
    check("col_req_addr",  32'(bus.imem_req_addr), 32'h40);
    check("col_req_valid", 32'(bus.imem_req_valid), 32'd1);
    @(negedge clk1);
    check("col_still_empty", 32'(bus.id_valid), 32'd0);
    @(negedge clk1);
    check("col_new_valid", 32'(bus.id_valid), 32'd1);
    check("col_new_ir",    bus.id_ir, 32'hA000_0040);
    check("col_new_npc",   bus.id_npc, 32'h41);

    // Halt with two requests in flight, then PC wrap
    lat = 3;
    do_reset(1'b1);
    @(negedge clk1);
    @(negedge clk1);
    halted = 1'b1;
    #1;
    check("halt_no_req", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk1);
    check("halt_empty",   32'(bus.id_valid), 32'd0);
    check("halt_no_req2", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk1);
    check("halt_w0_valid", 32'(bus.id_valid), 32'd1);
    check("halt_w0_ir",    bus.id_ir, 32'hA000_0000);
    check("halt_w0_npc",   bus.id_npc, 32'd1);
    @(negedge clk1);
    check("halt_w1_ir",    bus.id_ir, 32'hA000_0001);
    check("halt_w1_npc",   bus.id_npc, 32'd2);
    @(negedge clk1);
    check("halt_drained",  32'(bus.id_valid), 32'd0);
    check("halt_no_req3",  32'(bus.imem_req_valid), 32'd0);
    halted         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk1);
    redirect_valid = 1'b0;
    #1;
    check("wrap_pc_top",   pc, 32'hFFFF_FFFF);
    check("wrap_req_addr", 32'(bus.imem_req_addr), 32'h3FF);
    @(negedge clk1);
    check("wrap_pc_zero",  pc, 32'd0);
    repeat (3) @(negedge clk1);
    check("wrap_ir",  bus.id_ir, 32'hA000_03FF);
    check("wrap_npc", bus.id_npc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
